serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor computing d = x - y - b_in, LSB first, one bit per clock.
- Arithmetic inverse of the combinational ripple full adder.
- Single-cycle start/ready handshake in; one-cycle done pulse out.
- Trades adder-style parallel logic for one full-subtractor cell, a shift register and a small FSM.

---
 rtl/serial_subtractor.sv | 159 +++++++++++++++
 tb/tb_serial_subtractor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, d = x - y - b_in, LSB first.
// One full-subtractor cell is reused for WIDTH clocks; a start/ready handshake
// launches an operation and a one-cycle done pulse marks d/b_out valid.
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds the signed-overflow
// output ovf, updated together with d.
module serial_subtractor #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b_in,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] x_sr_q, x_sr_d;
  logic [WIDTH-1:0] y_sr_q, y_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             brw_q, brw_d;
  logic             b_out_q, b_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef SERIAL_SUB_OVERFLOW_EN
  // Operand sign bits are shifted out of the operand registers, so keep copies.
  logic x_msb_q, x_msb_d;
  logic y_msb_q, y_msb_d;
  logic ovf_q, ovf_d;
`endif

  logic xi, yi, dbit, brw_nxt, last_bit;

  // Full-subtractor cell on the current LSB of each operand register.
  always_comb begin
    xi       = x_sr_q[0];
    yi       = y_sr_q[0];
    dbit     = xi ^ yi ^ brw_q;
    brw_nxt  = (~xi & yi) | (~(xi ^ yi) & brw_q);
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Next-state logic; unencoded states fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, shift one bit per SHIFT edge, publish on the last bit.
  always_comb begin
    x_sr_d  = x_sr_q;
    y_sr_d  = y_sr_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    b_out_d = b_out_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    x_msb_d = x_msb_q;
    y_msb_d = y_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          x_sr_d = x;
          y_sr_d = y;
          brw_d  = b_in;
          res_d  = '0;
          cnt_d  = '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
          x_msb_d = x[WIDTH-1];
          y_msb_d = y[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        x_sr_d = x_sr_q >> 1;
        y_sr_d = y_sr_q >> 1;
        res_d  = {dbit, res_q[WIDTH-1:1]};
        brw_d  = brw_nxt;
        cnt_d  = cnt_q + CNT_W'(1);
        if (last_bit) begin
          d_d     = {dbit, res_q[WIDTH-1:1]};
          b_out_d = brw_nxt;
`ifdef SERIAL_SUB_OVERFLOW_EN
          // dbit is the MSB of the difference on the last shift.
          ovf_d = (x_msb_q != y_msb_q) && (dbit != x_msb_q);
`endif
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_sr_q  <= '0;
      y_sr_q  <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      b_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      x_msb_q <= 1'b0;
      y_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_sr_q  <= x_sr_d;
      y_sr_q  <= y_sr_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      b_out_q <= b_out_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      x_msb_q <= x_msb_d;
      y_msb_q <= y_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign d     = d_q;
  assign b_out = b_out_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH=3): vector table, random ops against
// an arithmetic reference model, and hand sequences for handshake corner cases.
module tb_serial_subtractor;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         b_in = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         ready, done, b_out;
  logic [W-1:0] d;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .b_in  (b_in),
    .ready (ready),
    .done  (done),
    .d     (d),
    .b_out (b_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         b;
    logic [W-1:0] ed;
    logic         ebo;
    logic         eovf;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range check for overflow.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] bb, input logic bi,
                                output logic [W-1:0] md, output logic mbo, output logic movf);
    int diff, sa, sb, sd;
    diff = int'(a) - int'(bb) - int'(bi);
    md   = diff[W-1:0];
    mbo  = (diff < 0);
    sa   = int'($signed(a));
    sb   = int'($signed(bb));
    sd   = sa - sb - int'(bi);
    movf = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
  endfunction

  // Called #1 after an edge with the DUT idle; returns #1 after the edge following done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] bb, input logic bi,
                        input logic [W-1:0] ed, input logic ebo, input logic eovf,
                        input string tag);
    logic [W-1:0] dprev;
    int k;
    bit got;
    chk({tag, " ready_pre"}, ready, 1);
    x = a; y = bb; b_in = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dprev = d;
    k = 0;
    got = 0;
    while (k < 20 && !got) begin
      chk({tag, " ready_busy"}, ready, 0);
      @(posedge clk); #1;
      k++;
      if (done) got = 1;
      else chk({tag, " d_stable"}, d, dprev);
    end
    chk({tag, " done_seen"}, got, 1);
    chk({tag, " latency"}, k, W);
    chk($sformatf("%s d (ovf exp %0b)", tag, eovf), d, ed);
    chk({tag, " b_out"}, b_out, ebo);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk({tag, " ovf"}, ovf, eovf);
`endif
    chk({tag, " ready_in_done"}, ready, 0);
    @(posedge clk); #1;
    chk({tag, " done_pulse_end"}, done, 0);
    chk({tag, " ready_back"}, ready, 1);
  endtask

  initial begin
    logic [W-1:0] md;
    logic         mbo, movf;
    logic [W-1:0] lastd;
    int           cnt, cyc, prev_done, n_done;
    logic [W:0]   q[$];
    logic [W:0]   e;

    vecs[0] = '{x: 3'b000, y: 3'b000, b: 1'b0, ed: 3'b000, ebo: 1'b0, eovf: 1'b0};
    vecs[1] = '{x: 3'b101, y: 3'b011, b: 1'b0, ed: 3'b010, ebo: 1'b0, eovf: 1'b1};
    vecs[2] = '{x: 3'b011, y: 3'b101, b: 1'b0, ed: 3'b110, ebo: 1'b1, eovf: 1'b1};
    vecs[3] = '{x: 3'b000, y: 3'b000, b: 1'b1, ed: 3'b111, ebo: 1'b1, eovf: 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", ready, 1);
    chk("rst done", done, 0);
    chk("rst d", d, 0);
    chk("rst b_out", b_out, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("rst ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 4; i++)
      run_op(vecs[i].x, vecs[i].y, vecs[i].b, vecs[i].ed, vecs[i].ebo, vecs[i].eovf,
             $sformatf("vec%0d", i));

    // Random operations against the model
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] a, bb;
      logic bi;
      a  = W'($urandom);
      bb = W'($urandom);
      bi = 1'($urandom);
      model(a, bb, bi, md, mbo, movf);
      run_op(a, bb, bi, md, mbo, movf, $sformatf("rnd%0d", i));
    end

    // start during SHIFT is ignored; operand changes after accept have no effect
    x = 3'b101; y = 3'b011; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; x = 3'b111; y = 3'b001; b_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; x = '0; y = '0; b_in = 1'b0;
    cnt = 2;
    while (cnt < 20 && !done) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("ign done_seen", done, 1);
    chk("ign latency", cnt, W);
    chk("ign d", d, 3'b010);
    chk("ign b_out", b_out, 0);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("ign extra_done", n_done, 0);
    chk("ign ready", ready, 1);

    // Reset one edge after accept aborts the op and clears the result
    x = 3'b011; y = 3'b101; b_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort ready", ready, 1);
    chk("abort done", done, 0);
    chk("abort d", d, 0);
    chk("abort b_out", b_out, 0);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("abort no_done", n_done, 0);

    // Back-to-back with start held high and operands changing every cycle
    start = 1'b1;
    lastd = d;
    cyc = 0;
    prev_done = -1;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom); y = W'($urandom); b_in = 1'($urandom);
      if (ready) begin
        model(x, y, b_in, md, mbo, movf);
        q.push_back({mbo, md});
      end
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        n_done++;
        if (q.size() == 0) chk("b2b unexpected_done", done, 0);
        else begin
          e = q.pop_front();
          chk("b2b d", d, e[W-1:0]);
          chk("b2b b_out", b_out, e[W]);
        end
        if (prev_done >= 0) chk("b2b spacing", cyc - prev_done, W + 2);
        prev_done = cyc;
        lastd = d;
      end else begin
        chk("b2b d_hold", d, lastd);
      end
    end
    start = 1'b0;
    chk("b2b done_count", n_done, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
